// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT front-end defaults and the ping-pong bank-state encoding.
package fft_pkg;
    localparam int bw_fftp_def = 10;
    localparam int bw_data_def = 16;
    typedef enum logic [1:0] {EMPTY = 2'd0, FILL = 2'd1, FULL = 2'd2, BUSY = 2'd3} bank_st_t;
endpackage

// File: rtl/BitReverse.sv
// BitReverse: mirrors the bit order of an FFT point index.
module BitReverse #(
    parameter int bw_fftp = 10
) (
    input  logic [bw_fftp-1:0] addr_i,
    output logic [bw_fftp-1:0] addr_o
);
    for (genvar i = 0; i < bw_fftp; i++) begin : g_rev
        assign addr_o[i] = addr_i[bw_fftp-1-i];
    end
endmodule

// File: rtl/fft_reorder_ram.sv
// fft_reorder_ram: simple dual-port RAM, one write port and one registered read port.
module fft_reorder_ram #(
    parameter int aw = 11,
    parameter int dw = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [aw-1:0] wa_i,
    input  logic [dw-1:0] wd_i,
    input  logic [aw-1:0] ra_i,
    output logic [dw-1:0] rd_o
);
    logic [dw-1:0] mem [2**aw];
    logic [dw-1:0] rd_q;
    always_ff @(posedge clk)
        if (we_i) mem[wa_i] <= wd_i;
    always_ff @(posedge clk)
        rd_q <= rst ? '0 : mem[ra_i];
    assign rd_o = rd_q;
endmodule

// File: rtl/fft_input_reorder.sv
// fft_input_reorder: ping-pong bit-reversed frame buffer feeding the FFT core.
// Optional dropped-sample counter OvfCnt enabled by REORDER_OVF_CNT_EN.
module fft_input_reorder
    import fft_pkg::*;
#(
    parameter int bw_fftp = bw_fftp_def,
    parameter int bw_data = bw_data_def
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               InValid,
    input  logic [bw_data-1:0] InData,
    output logic               InReady,
    output logic               FrameValid,
    input  logic               FrameStart,
    input  logic               FrameDone,
    input  logic [bw_fftp-1:0] RdAddr,
    output logic [bw_data-1:0] RdData,
`ifdef REORDER_OVF_CNT_EN
    output logic [15:0]        OvfCnt,
`endif
    output logic               RdBank
);
    bank_st_t st_q [2];
    bank_st_t st_d [2];
    logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [bw_fftp-1:0] wr_cnt_q, wr_addr;
    logic wr_en, eof, busy, sel;

    BitReverse #(.bw_fftp(bw_fftp)) u_rev (.addr_i(wr_cnt_q), .addr_o(wr_addr));

    fft_reorder_ram #(.aw(bw_fftp + 1), .dw(bw_data)) u_ram (
        .clk(Clk), .rst(Rst), .we_i(wr_en), .wa_i({wr_bank_q, wr_addr}), .wd_i(InData),
        .ra_i({rd_bank_q, RdAddr}), .rd_o(RdData)
    );

    assign InReady    = st_q[wr_bank_q] == FILL;
    assign wr_en      = InValid && InReady;
    assign eof        = wr_en && &wr_cnt_q;
    assign FrameValid = (st_q[0] == FULL || st_q[1] == FULL) && st_q[0] != BUSY && st_q[1] != BUSY;
    assign RdBank     = rd_bank_q;

    // Release first so a same-cycle claim sees the freed bank; promotion only
    // looks at registered state, giving the one-cycle EMPTY->FILL delay.
    always_comb begin
        st_d      = st_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (FrameDone && st_q[0] == BUSY) st_d[0] = EMPTY;
        if (FrameDone && st_q[1] == BUSY) st_d[1] = EMPTY;
        busy = st_d[0] == BUSY || st_d[1] == BUSY;
        sel  = st_d[!wr_bank_q] == FULL ? !wr_bank_q : wr_bank_q;
        if (FrameStart && !busy && st_d[sel] == FULL) begin
            st_d[sel] = BUSY;
            rd_bank_d = sel;
        end
        if (eof) st_d[wr_bank_q] = FULL;
        if ((eof || st_q[wr_bank_q] != FILL) && st_q[!wr_bank_q] == EMPTY) begin
            st_d[!wr_bank_q] = FILL;
            wr_bank_d        = !wr_bank_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            st_q[0]   <= FILL;
            st_q[1]   <= EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
        end else begin
            st_q      <= st_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_q + bw_fftp'(wr_en);
        end
    end

`ifdef REORDER_OVF_CNT_EN
    logic [15:0] ovf_q;
    always_ff @(posedge Clk) begin
        if (Rst) ovf_q <= '0;
        else if (InValid && !InReady && !(&ovf_q)) ovf_q <= ovf_q + 16'd1;
    end
    assign OvfCnt = ovf_q;
`endif
endmodule

// File: tb/tb_fft_input_reorder.sv
// tb_fft_input_reorder: directed scenarios plus random traffic against a frame-queue model.
module tb_fft_input_reorder;
    localparam int FP = 3;
    localparam int DW = 16;
    localparam int N  = 8;

    logic          Clk = 1'b0;
    logic          Rst, InValid, InReady, FrameValid, FrameStart, FrameDone, RdBank;
    logic [DW-1:0] InData, RdData;
    logic [FP-1:0] RdAddr;
`ifdef REORDER_OVF_CNT_EN
    logic [15:0]   OvfCnt;
`endif

    int errors = 0;
    int checks = 0;
    int m_mem [2][N];
    bit m_wr  [2][N];
    int m_full [$];
    int m_fill, m_cnt, m_busy, m_free, m_rdbank, m_ovf;
    int brev_tbl [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int k, nst;
    bit s, dn, v;

    always #5 Clk = ~Clk;

    fft_input_reorder #(.bw_fftp(FP), .bw_data(DW)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InData(InData), .InReady(InReady),
        .FrameValid(FrameValid), .FrameStart(FrameStart), .FrameDone(FrameDone),
        .RdAddr(RdAddr), .RdData(RdData),
`ifdef REORDER_OVF_CNT_EN
        .OvfCnt(OvfCnt),
`endif
        .RdBank(RdBank)
    );

    function automatic int rev(int x);
        int r = 0;
        for (int i = 0; i < FP; i++) r = r * 2 + ((x >> i) & 1);
        return r;
    endfunction

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Frame-level model: fill bank (-1 = stalled), FIFO of full banks, claimed bank, freed bank.
    task automatic m_step(bit vv, int d, bit st, bit dd);
        int old_free = m_free;
        int freed = -1;
        bit rdy = m_fill >= 0;
        if (dd && m_busy >= 0) begin freed = m_busy; m_busy = -1; end
        if (st && m_busy < 0 && m_full.size() > 0) begin
            m_busy = m_full.pop_front();
            m_rdbank = m_busy;
        end
        if (vv && rdy) begin
            m_mem[m_fill][rev(m_cnt)] = d & 16'hFFFF;
            m_wr[m_fill][rev(m_cnt)] = 1'b1;
            m_cnt = (m_cnt + 1) % N;
            if (m_cnt == 0) begin
                m_full.push_back(m_fill);
                m_fill = old_free;
                old_free = -1;
            end
        end else if (!rdy && old_free >= 0) begin
            m_fill = old_free;
            old_free = -1;
        end
        m_free = freed >= 0 ? freed : old_free;
        if (vv && !rdy && m_ovf < 65535) m_ovf++;
    endtask

    task automatic check_outputs();
        check("InReady", int'(InReady), int'(m_fill >= 0));
        check("FrameValid", int'(FrameValid), int'(m_full.size() > 0 && m_busy < 0));
        check("RdBank", int'(RdBank), m_rdbank);
`ifdef REORDER_OVF_CNT_EN
        check("OvfCnt", int'(OvfCnt), m_ovf);
`endif
    endtask

    task automatic cyc(bit vv, int d, bit st, bit dd, int a);
        bit rd_ok;
        int rd_exp;
        InValid = vv; InData = DW'(d); FrameStart = st; FrameDone = dd; RdAddr = FP'(a);
        rd_ok  = m_wr[m_rdbank][a];
        rd_exp = m_mem[m_rdbank][a];
        m_step(vv, d, st, dd);
        @(posedge Clk); #1;
        check_outputs();
        if (rd_ok) check("RdData", int'(RdData), rd_exp);
    endtask

    task automatic do_reset();
        Rst = 1'b1; InValid = 1'b0; InData = '0; FrameStart = 1'b0; FrameDone = 1'b0; RdAddr = '0;
        @(posedge Clk); #1;
        Rst = 1'b0;
        m_fill = 0; m_cnt = 0; m_busy = -1; m_free = 1; m_rdbank = 0; m_ovf = 0;
        m_full.delete();
        check_outputs();
        check("rst_InReady", int'(InReady), 1);
        check("rst_FrameValid", int'(FrameValid), 0);
        check("rst_RdData", int'(RdData), 0);
    endtask

    initial begin
        // bit-reversal placement
        do_reset();
        for (int i = 0; i < N; i++) begin
            cyc(1'b1, i, 1'b0, 1'b0, 0);
            check("brev_fv", int'(FrameValid), int'(i == N - 1));
        end
        cyc(1'b0, 0, 1'b1, 1'b0, 0);
        check("brev_rdbank", int'(RdBank), 0);
        for (int a = 0; a < N; a++) begin
            cyc(1'b0, 0, 1'b0, 1'b0, a);
            check("brev_data", int'(RdData), brev_tbl[a]);
        end
        cyc(1'b0, 0, 1'b0, 1'b1, 0);

        // ping-pong continuity
        do_reset();
        k = -1; nst = 0;
        for (int c = 0; c < 40; c++) begin
            s  = FrameValid && k < 0;
            dn = k == 4;
            cyc(c < 24, 1000 + c, s, dn, c % N);
            if (c < 24) check("pp_ready", int'(InReady), 1);
            if (s) begin
                check("pp_rdbank", int'(RdBank), nst % 2);
                nst++;
                k = 0;
            end else if (k >= 0) k = dn ? -1 : k + 1;
        end
        check("pp_frames", nst, 3);

        // overflow stall
        do_reset();
        for (int i = 0; i < 2 * N; i++) cyc(1'b1, 300 + i, 1'b0, 1'b0, 0);
        check("ovf_stall", int'(InReady), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 999, 1'b0, 1'b0, 0);
            check("ovf_drop_rdy", int'(InReady), 0);
        end
`ifdef REORDER_OVF_CNT_EN
        check("ovf_cnt", int'(OvfCnt), 4);
`endif
        cyc(1'b0, 0, 1'b1, 1'b0, 0);
        check("ovf_claim", int'(RdBank), 0);
        for (int a = 0; a < N; a++) begin
            cyc(1'b0, 0, 1'b0, 1'b0, a);
            check("ovf_data", int'(RdData), 300 + brev_tbl[a]);
        end
        cyc(1'b0, 0, 1'b0, 1'b1, 0);
        check("ovf_rdy_d0", int'(InReady), 0);
        cyc(1'b0, 0, 1'b0, 1'b0, 0);
        check("ovf_rdy_d1", int'(InReady), 1);
        cyc(1'b0, 0, 1'b1, 1'b0, 0);
        check("ovf_claim2", int'(RdBank), 1);
        cyc(1'b0, 0, 1'b0, 1'b1, 0);

        // simultaneous FrameDone and end-of-frame write
        do_reset();
        for (int i = 0; i < N; i++) cyc(1'b1, i, 1'b0, 1'b0, 0);
        cyc(1'b1, N, 1'b1, 1'b0, 0);
        for (int i = 0; i < N - 2; i++) cyc(1'b1, N + 1 + i, 1'b0, 1'b0, 0);
        cyc(1'b1, 2 * N - 1, 1'b0, 1'b1, 0);
        check("sim_rdy0", int'(InReady), 0);
        check("sim_fv", int'(FrameValid), 1);
        cyc(1'b0, 0, 1'b0, 1'b0, 0);
        check("sim_rdy1", int'(InReady), 1);

        // reset mid-frame
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 100 + i, 1'b0, 1'b0, 0);
        do_reset();
        for (int i = 0; i < N; i++) cyc(1'b1, 200 + i, 1'b0, 1'b0, 0);
        cyc(1'b0, 0, 1'b1, 1'b0, 0);
        check("rst_claim", int'(RdBank), 0);
        for (int a = 0; a < N; a++) begin
            cyc(1'b0, 0, 1'b0, 1'b0, a);
            check("rst_data", int'(RdData), 200 + brev_tbl[a]);
        end

        // spurious controls
        do_reset();
        cyc(1'b0, 0, 1'b1, 1'b0, 0);
        check("sp_start_rdy", int'(InReady), 1);
        check("sp_start_fv", int'(FrameValid), 0);
        cyc(1'b0, 0, 1'b0, 1'b1, 0);
        check("sp_done_rdy", int'(InReady), 1);
        check("sp_done_fv", int'(FrameValid), 0);
        for (int i = 0; i < N; i++) cyc(1'b1, 50 + i, 1'b0, i == 3, 0);
        check("sp_frame", int'(FrameValid), 1);

        // random traffic
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            v  = $urandom_range(0, 3) != 0;
            s  = $urandom_range(0, 5) == 0;
            dn = $urandom_range(0, 6) == 0;
            cyc(v, int'($urandom_range(0, 65535)), s, dn, int'($urandom_range(0, N - 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fft_input_reorder.md
Name: fft_input_reorder

Overview:
- Ping-pong frame buffer directly upstream of the FFT butterfly core.
- Accepts a continuous stream of audio samples in natural order.
- Writes each sample to RAM at the bit-reversed index of its position in the frame. It instantiates BitReverse for this.
- The FFT core can then read a complete frame in natural address order while the next frame fills the other bank.

Parameters:
- bw_fftp, 10, log2 of FFT points (frame length N = 2**bw_fftp)
- bw_data, 16, sample width (two's complement)

Ports:
- Clk  input  1  system clock
- Rst  input  1  synchronous active-high reset
- InValid  input  1  sample strobe
- InData  input  bw_data  sample
- InReady  output  1  block can accept a sample this cycle
- FrameValid  output  1  a full bank is waiting for the FFT
- FrameStart  input  1  pulse from FFT: claim waiting bank
- FrameDone  input  1  pulse from FFT: release claimed bank
- RdAddr  input  bw_fftp  FFT read address (natural order)
- RdData  output  bw_data  RAM word at RdAddr of claimed bank, 1-cycle latency
- RdBank  output  1  index of bank currently claimed by FFT

Behaviour:
- Storage: two banks of N x bw_data, inferred as simple dual-port RAM. Write port is on the fill side; read port is on the FFT side.
- Per-bank state (2 bits): EMPTY, FILL, FULL, BUSY.
- Reset:
  - bank0=FILL, bank1=EMPTY, WrBank=0, WrCnt=0.
  - InReady=1, FrameValid=0, RdBank=0, RdData=0.
- Write path:
  - On InValid&&InReady: RAM[WrBank][BitReverse(WrCnt)] <= InData; WrCnt <= WrCnt+1.
  - WrCnt wraps mod N.
- End of frame: when a write occurs with WrCnt==N-1:
  - The fill bank goes FILL->FULL.
  - If the other bank is EMPTY, it goes to FILL and WrBank toggles in the same cycle, so no stall.
  - Otherwise WrBank is unchanged and InReady drops to 0.
- Stall: InReady = (state[WrBank]==FILL). While stalled, samples with InValid=1 are dropped, not queued.
  - When the other bank becomes EMPTY, the next cycle sets it to FILL, toggles WrBank and raises InReady.
- FrameValid: 1 while any bank is FULL and no bank is BUSY.
- FrameStart when FrameValid=1:
  - The oldest FULL bank goes to BUSY and RdBank takes its index.
  - Only one bank can be FULL at a time while the other is BUSY or FILL, so "oldest" is unambiguous.
- FrameStart when FrameValid=0: ignored.
- FrameDone when a bank is BUSY: that bank goes to EMPTY. FrameDone with no BUSY bank is ignored.
- Simultaneous FrameDone and end-of-frame write: both take effect. The freed bank becomes EMPTY this cycle and is promoted to FILL on the following cycle. InReady is 0 for exactly one cycle.
- Simultaneous FrameStart and FrameDone: FrameDone is applied first, then FrameStart is evaluated on the updated states (back-to-back frames).
- Read: RdData <= RAM[RdBank][RdAddr] every cycle, registered. Reading a non-BUSY bank returns stale data; this is legal and not flagged.
- Rst mid-frame: all state returns to reset values, and the partial frame is discarded. RAM contents are not cleared.

Optional Feature:
- Macro: REORDER_OVF_CNT_EN.
- When defined:
  - Adds output OvfCnt [15:0], reset to 0.
  - Increments on every cycle with InValid&&!InReady.
  - Saturates at 16'hFFFF.
  - Cleared only by Rst.
- When undefined: the port and counter are absent, and dropped samples are silent.

Decomposition:
- Shared package fft_pkg holds:
  - bw_fftp and bw_data defaults.
  - The bank-state encoding: EMPTY=2'd0, FILL=2'd1, FULL=2'd2, BUSY=2'd3.
- Address reversal is done by instantiating the existing BitReverse sub-module with .bw_fftp(bw_fftp) on WrCnt. No new reversal logic.
- The bank RAM is a natural second sub-module: fft_reorder_ram, a generic dual-port RAM.

Test Plan:
- Bit-reversal placement (bw_fftp=3, bw_data=16):
  - Stimulus: write samples 0..7, FrameStart, read RdAddr 0..7.
  - Response: RdData sequence 0,4,2,6,1,5,3,7, each 1 cycle after its address. FrameValid rises the cycle after sample 7.
- Ping-pong continuity:
  - Stimulus: 24 consecutive samples with InValid=1 every cycle, FFT doing FrameStart/FrameDone within 8 cycles.
  - Response: InReady stays 1 throughout; RdBank alternates 0,1,0.
- Overflow stall:
  - Stimulus: 16 samples with no FrameStart/FrameDone, then 4 more.
  - Response: InReady=0 after sample 16; the last 4 are dropped (OvfCnt=4 if REORDER_OVF_CNT_EN).
  - Then FrameStart+FrameDone: InReady returns to 1 two cycles after FrameDone.
- Simultaneous events:
  - Stimulus: FrameDone in the same cycle as the end-of-frame write of the other bank.
  - Response: exactly one InReady=0 cycle. FrameValid=1 the next cycle.
- Reset mid-frame:
  - Stimulus: write 5 samples, pulse Rst, write 8 samples, FrameStart.
  - Response: bank 0 is read back in bit-reversed order containing only the post-reset 8 samples. FrameValid=0 during and right after Rst.
- Spurious controls:
  - Stimulus: FrameStart with FrameValid=0; FrameDone with no BUSY bank.
  - Response: no state change; InReady and FrameValid are unchanged.
